// File: rtl/flash_sector.sv
// Word-addressed flash array with multi-cycle program, sector/chip erase,
// low-sector write protection and coded error reporting.
module flash_sector #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int SECTOR_W    = 6,
  parameter int PROG_CYCLES = 4,
  parameter int WP_SECTORS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              erase_en,
  input  logic              erase_all,
  input  logic              wp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] idata,
  output logic [DATA_W-1:0] odata,
  output logic              rvalid,
  output logic              busy,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PROG  = 2'd1;
  localparam logic [1:0] ST_ERASE = 2'd2;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_NOT_ERASED = 2'b01;
  localparam logic [1:0] ERR_PROTECTED  = 2'b10;
  localparam logic [1:0] ERR_BUSY       = 2'b11;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              rvalid_q, rvalid_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              any_cmd;
  logic              sec_protected;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    end_d      = end_q;
    paddr_d    = paddr_q;
    pdata_d    = pdata_q;
    odata_d    = odata_q;
    err_code_d = err_code_q;
    rvalid_d   = 1'b0;
    error_d    = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = '0;

    any_cmd       = en && (rd_en || wr_en || erase_en);
    sec_protected = wp && (32'(addr[ADDR_W-1:SECTOR_W]) < WP_SECTORS);

    case (state_q)
      ST_IDLE: begin
        if (en && rd_en) begin
          odata_d    = mem_q[addr];
          rvalid_d   = 1'b1;
          err_code_d = ERR_NONE;
        end else if (en && wr_en) begin
          if (sec_protected) begin
            error_d    = 1'b1;
            err_code_d = ERR_PROTECTED;
          end else if (mem_q[addr] != '0) begin
            error_d    = 1'b1;
            err_code_d = ERR_NOT_ERASED;
          end else begin
            paddr_d    = addr;
            pdata_d    = idata;
            cnt_d      = CNT_W'(PROG_CYCLES - 1);
            state_d    = ST_PROG;
            err_code_d = ERR_NONE;
          end
        end else if (en && erase_en) begin
          // Chip erase under wp is refused outright rather than skipping protected sectors
          if (wp && (erase_all || sec_protected)) begin
            error_d    = 1'b1;
            err_code_d = ERR_PROTECTED;
          end else begin
            ptr_d      = erase_all ? '0 : {addr[ADDR_W-1:SECTOR_W], {SECTOR_W{1'b0}}};
            end_d      = erase_all ? '1 : {addr[ADDR_W-1:SECTOR_W], {SECTOR_W{1'b1}}};
            state_d    = ST_ERASE;
            err_code_d = ERR_NONE;
          end
        end
      end
      ST_PROG: begin
        if (cnt_q == '0) begin
          mem_we    = 1'b1;
          mem_waddr = paddr_q;
          mem_wdata = pdata_q;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ERASE: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        if (ptr_q == end_q) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && any_cmd) begin
      error_d    = 1'b1;
      err_code_d = ERR_BUSY;
    end

    busy_d = (state_d != ST_IDLE);

    // A reset edge must not commit the pending program/erase word
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      end_q      <= '0;
      paddr_q    <= '0;
      pdata_q    <= '0;
      odata_q    <= '0;
      rvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      end_q      <= end_d;
      paddr_q    <= paddr_d;
      pdata_q    <= pdata_d;
      odata_q    <= odata_d;
      rvalid_q   <= rvalid_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  // Array contents are non-volatile, so the storage has no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign odata    = odata_q;
  assign rvalid   = rvalid_q;
  assign busy     = busy_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule
